// File: rtl/data_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles both requester ports and the data-memory port of data_mem_arbiter.
//
// Handshake: a requester raises rN_req with addr/we/size/signed/wdata stable
// and keeps them stable until it sees rN_ack. rN_ack is a single-cycle pulse.
// rN_err and rN_rdata are meaningful only in that cycle. After the ack the
// requester may drop rN_req or present a new request on the next cycle.
//
// Signals (N = 0 CPU load/store port, N = 1 DMA port):
//   rN_req/rN_addr/rN_we/rN_size/rN_signed/rN_wdata  requester -> arbiter
//   rN_ack/rN_err/rN_rdata                           arbiter -> requester
//   mem_addr/mem_wdata/mem_wren                       arbiter -> memory
//   mem_rdata                                         memory -> arbiter (async)
// Modports: master = requesters plus memory side, slave = the arbiter.
// -----------------------------------------------------------------------------
interface data_mem_arbiter_if;
    logic        r0_req;
    logic [31:0] r0_addr;
    logic        r0_we;
    logic [1:0]  r0_size;
    logic        r0_signed;
    logic [31:0] r0_wdata;
    logic        r0_ack;
    logic        r0_err;
    logic [31:0] r0_rdata;

    logic        r1_req;
    logic [31:0] r1_addr;
    logic        r1_we;
    logic [1:0]  r1_size;
    logic        r1_signed;
    logic [31:0] r1_wdata;
    logic        r1_ack;
    logic        r1_err;
    logic [31:0] r1_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wren;
    logic [31:0] mem_rdata;

    modport master (
        output r0_req, r0_addr, r0_we, r0_size, r0_signed, r0_wdata,
        input  r0_ack, r0_err, r0_rdata,
        output r1_req, r1_addr, r1_we, r1_size, r1_signed, r1_wdata,
        input  r1_ack, r1_err, r1_rdata,
        input  mem_addr, mem_wdata, mem_wren,
        output mem_rdata
    );

    modport slave (
        input  r0_req, r0_addr, r0_we, r0_size, r0_signed, r0_wdata,
        output r0_ack, r0_err, r0_rdata,
        input  r1_req, r1_addr, r1_we, r1_size, r1_signed, r1_wdata,
        output r1_ack, r1_err, r1_rdata,
        output mem_addr, mem_wdata, mem_wren,
        input  mem_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Two-requester front end for a byte-laned 32-bit data memory with
// combinational read and posedge byte-lane write. Picks one of the CPU port
// (r0) and DMA port (r1), turns byte/half/word accesses into a word address,
// lane enables and lane-positioned write data, and aligns/extends read data.
//
// Optional feature: define MEM_ARB_MISALIGN_SPLIT_EN to perform misaligned
// half/word accesses as two word cycles (ACC_HI). Without it a misaligned
// access is answered with err=1 and never reaches memory.
//
// Parameters:
//   PRIO_FIXED   0 = round-robin on simultaneous requests, 1 = r0 always wins
// Ports:
//   clk          clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   bus_if       data_mem_arbiter_if.slave (requester ports + memory port)
//   dbg_state_o  current FSM state (0 IDLE, 1 ACC_LO, 2 ACC_HI, 3 RESP)
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_arbiter_if.slave bus_if,
    output logic [1:0]        dbg_state_o
);

`ifdef MEM_ARB_MISALIGN_SPLIT_EN
    localparam int SPAN = 2;
`else
    localparam int SPAN = 1;
`endif
    localparam bit SPLIT = (SPAN == 2);
    localparam int LMW   = 4 * SPAN;    // lane mask width over the words touched
    localparam int DW    = 32 * SPAN;   // data width over the words touched

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e      state_q;
    logic        last_q;        // 1 = r1 was granted most recently
    logic [1:0]  ack_q;         // one-hot per port, high only in RESP
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wren_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        sgn_q;
`ifdef MEM_ARB_MISALIGN_SPLIT_EN
    logic [29:0] word_hi_q;     // next word index, wraps mod 2^30
    logic [3:0]  mask_hi_q;     // nonzero exactly when the access crosses a word
    logic [31:0] wdata_hi_q;
    logic [31:0] lo_q;
`endif

    // Request selection and lane decode for the access seen in IDLE
    logic           grant_r1;
    logic [31:0]    sel_addr;
    logic [31:0]    sel_wdata;
    logic           sel_we;
    logic           sel_sgn;
    logic [1:0]     sel_size;
    logic [1:0]     sel_off;
    logic [3:0]     base;
    logic [LMW-1:0] lane_mask;
    logic [DW-1:0]  wdata_pos;
    logic           misaligned;
    logic           reject;

    always_comb begin
        if (bus_if.r0_req && bus_if.r1_req) begin
            grant_r1 = PRIO_FIXED ? 1'b0 : ~last_q;
        end else begin
            grant_r1 = bus_if.r1_req;
        end
        sel_addr  = grant_r1 ? bus_if.r1_addr   : bus_if.r0_addr;
        sel_wdata = grant_r1 ? bus_if.r1_wdata  : bus_if.r0_wdata;
        sel_we    = grant_r1 ? bus_if.r1_we     : bus_if.r0_we;
        sel_sgn   = grant_r1 ? bus_if.r1_signed : bus_if.r0_signed;
        sel_size  = grant_r1 ? bus_if.r1_size   : bus_if.r0_size;
        sel_off   = sel_addr[1:0];
        case (sel_size)
            2'b00:   base = 4'h1;
            2'b01:   base = 4'h3;
            default: base = 4'hF;
        endcase
        lane_mask  = LMW'(base) << sel_off;
        wdata_pos  = DW'(sel_wdata) << {sel_off, 3'b000};
        misaligned = ((sel_size == 2'b10) && (sel_off != 2'b00)) ||
                     ((sel_size == 2'b01) && (sel_off == 2'b11));
        reject     = (sel_size == 2'b11) | (misaligned & ~SPLIT);
    end

    // Shift the captured word(s) down by the byte offset, then extend.
    function automatic logic [31:0] load_fmt(input logic [DW-1:0] raw,
                                             input logic [1:0]    off,
                                             input logic [1:0]    size,
                                             input logic          sgn);
        logic [31:0] d;
        d = 32'(raw >> {off, 3'b000});
        case (size)
            2'b00:   load_fmt = {{24{sgn & d[7]}}, d[7:0]};
            2'b01:   load_fmt = {{16{sgn & d[15]}}, d[15:0]};
            default: load_fmt = d;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            ack_q       <= 2'b00;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wren_q  <= 4'h0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            sgn_q       <= 1'b0;
`ifdef MEM_ARB_MISALIGN_SPLIT_EN
            word_hi_q   <= 30'h0;
            mask_hi_q   <= 4'h0;
            wdata_hi_q  <= 32'h0;
            lo_q        <= 32'h0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_if.r0_req || bus_if.r1_req) begin
                        last_q <= grant_r1;
                        we_q   <= sel_we;
                        size_q <= sel_size;
                        off_q  <= sel_off;
                        sgn_q  <= sel_sgn;
`ifdef MEM_ARB_MISALIGN_SPLIT_EN
                        word_hi_q  <= sel_addr[31:2] + 30'd1;
                        mask_hi_q  <= lane_mask[7:4];
                        wdata_hi_q <= wdata_pos[63:32];
`endif
                        if (reject) begin
                            // No memory cycle: answer directly with an error.
                            ack_q   <= grant_r1 ? 2'b10 : 2'b01;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                            state_q <= RESP;
                        end else begin
                            mem_addr_q  <= {sel_addr[31:2], 2'b00};
                            mem_wdata_q <= wdata_pos[31:0];
                            mem_wren_q  <= sel_we ? lane_mask[3:0] : 4'h0;
                            state_q     <= ACC_LO;
                        end
                    end
                end
                ACC_LO: begin
`ifdef MEM_ARB_MISALIGN_SPLIT_EN
                    if (mask_hi_q != 4'h0) begin
                        lo_q        <= bus_if.mem_rdata;
                        mem_addr_q  <= {word_hi_q, 2'b00};
                        mem_wdata_q <= wdata_hi_q;
                        mem_wren_q  <= we_q ? mask_hi_q : 4'h0;
                        state_q     <= ACC_HI;
                    end else
`endif
                    begin
                        mem_wren_q <= 4'h0;
                        ack_q      <= last_q ? 2'b10 : 2'b01;
                        err_q      <= 1'b0;
                        rdata_q    <= we_q ? 32'h0
                                           : load_fmt(DW'(bus_if.mem_rdata), off_q, size_q, sgn_q);
                        state_q    <= RESP;
                    end
                end
`ifdef MEM_ARB_MISALIGN_SPLIT_EN
                ACC_HI: begin
                    mem_wren_q <= 4'h0;
                    ack_q      <= last_q ? 2'b10 : 2'b01;
                    err_q      <= 1'b0;
                    rdata_q    <= we_q ? 32'h0
                                       : load_fmt({bus_if.mem_rdata, lo_q}, off_q, size_q, sgn_q);
                    state_q    <= RESP;
                end
`endif
                RESP: begin
                    ack_q   <= 2'b00;
                    err_q   <= 1'b0;
                    rdata_q <= 32'h0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_wren_q <= 4'h0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus_if.r0_ack   = ack_q[0];
    assign bus_if.r1_ack   = ack_q[1];
    assign bus_if.r0_err   = ack_q[0] & err_q;
    assign bus_if.r1_err   = ack_q[1] & err_q;
    assign bus_if.r0_rdata = {32{ack_q[0]}} & rdata_q;
    assign bus_if.r1_rdata = {32{ack_q[1]}} & rdata_q;
    assign bus_if.mem_addr  = mem_addr_q;
    assign bus_if.mem_wdata = mem_wdata_q;
    assign bus_if.mem_wren  = mem_wren_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Drives rounds of requests on r0/r1, predicts every ack (cycle, err, rdata)
// and every memory write from a byte-addressed reference memory, and checks
// them as the DUT presents them. Follows MEM_ARB_MISALIGN_SPLIT_EN if defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_mem_arbiter;

    localparam bit PRIO = 1'b0;
`ifdef MEM_ARB_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
    } txn_t;

    // ---------------- clock / reset ----------------
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  dbg_state;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_arbiter_if bus();

    data_mem_arbiter #(.PRIO_FIXED(PRIO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus_if      (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- memory attached to the DUT ----------------
    logic [31:0] tb_mem [0:255] = '{default: 32'h0};

    assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];

    always @(posedge clk) begin
        if (bus.mem_wren[0]) tb_mem[bus.mem_addr[9:2]][7:0]   <= bus.mem_wdata[7:0];
        if (bus.mem_wren[1]) tb_mem[bus.mem_addr[9:2]][15:8]  <= bus.mem_wdata[15:8];
        if (bus.mem_wren[2]) tb_mem[bus.mem_addr[9:2]][23:16] <= bus.mem_wdata[23:16];
        if (bus.mem_wren[3]) tb_mem[bus.mem_addr[9:2]][31:24] <= bus.mem_wdata[31:24];
    end

    // ---------------- scoreboard state ----------------
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [64:0] exp_q0[$];      // {ack cycle, err, rdata}
    logic [64:0] exp_q1[$];
    logic [67:0] exp_wr_q[$];    // {word address, lane enables, lane data}
    logic [7:0]  ref_mem [0:1023] = '{default: 8'h00};
    int          last_grant = 1; // port granted most recently (1 after reset)

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] addr, input logic we, input logic [1:0] size,
                                input logic sgn, input logic [31:0] wdata);
        txn_t t;
        t.addr = addr; t.we = we; t.size = size; t.sgn = sgn; t.wdata = wdata;
        return t;
    endfunction

    // Reference: byte-level memory semantics of one access.
    task automatic model_exec(input txn_t t, output int lat, output logic err, output logic [31:0] rd);
        int n, off, a, wi, lane;
        logic [3:0]  wr0, wr1;
        logic [31:0] wd0, wd1, v;
        bit          crosses;
        n   = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
        off = int'(t.addr[1:0]);
        crosses = (off + n) > 4;
        rd = 32'h0; v = 32'h0;
        wr0 = 4'h0; wr1 = 4'h0; wd0 = 32'h0; wd1 = 32'h0;
        err = (t.size == 2'd3) || (crosses && !SPLIT);
        lat = 1;
        if (!err) begin
            lat = crosses ? 3 : 2;
            for (int i = 0; i < n; i++) begin
                a    = int'(t.addr[9:0]) + i;
                wi   = (a / 4) - int'(t.addr[9:2]);
                lane = a % 4;
                if (t.we) begin
                    ref_mem[a] = t.wdata[8*i +: 8];
                    if (wi == 0) begin
                        wr0[lane] = 1'b1;
                        wd0[8*lane +: 8] = t.wdata[8*i +: 8];
                    end else begin
                        wr1[lane] = 1'b1;
                        wd1[8*lane +: 8] = t.wdata[8*i +: 8];
                    end
                end else begin
                    v[8*i +: 8] = ref_mem[a];
                end
            end
            if (t.we) begin
                exp_wr_q.push_back({t.addr & 32'hFFFF_FFFC, wr0, wd0});
                if (crosses) exp_wr_q.push_back({(t.addr & 32'hFFFF_FFFC) + 32'd4, wr1, wd1});
            end else begin
                if (t.sgn && n == 1 && v[7])  v[31:8]  = 24'hFF_FFFF;
                if (t.sgn && n == 2 && v[15]) v[31:16] = 16'hFFFF;
                rd = v;
            end
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a posedge with the DUT idle; returns the same way.
    task automatic issue_round(input bit v0, input txn_t t0, input bit v1, input txn_t t1);
        int          first, p, lat, start, budget;
        logic        err;
        logic [31:0] rd;
        bit          done0, done1;
        start = int'(cyc);
        if (v0 && v1) first = PRIO ? 0 : ((last_grant == 1) ? 0 : 1);
        else          first = v0 ? 0 : 1;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? first : 1 - first;
            if ((p == 0 && v0) || (p == 1 && v1)) begin
                model_exec((p == 0) ? t0 : t1, lat, err, rd);
                start += lat;
                if (p == 0) exp_q0.push_back({32'(start), err, rd});
                else        exp_q1.push_back({32'(start), err, rd});
                start += 1;   // idle cycle before the next grant
                last_grant = p;
            end
        end
        bus.r0_req = v0; bus.r0_addr = t0.addr; bus.r0_we = t0.we;
        bus.r0_size = t0.size; bus.r0_signed = t0.sgn; bus.r0_wdata = t0.wdata;
        bus.r1_req = v1; bus.r1_addr = t1.addr; bus.r1_we = t1.we;
        bus.r1_size = t1.size; bus.r1_signed = t1.sgn; bus.r1_wdata = t1.wdata;
        done0 = !v0; done1 = !v1; budget = 0;
        while (!(done0 && done1) && budget < 20) begin
            @(negedge clk);
            budget++;
            if (bus.r0_ack) begin done0 = 1'b1; bus.r0_req = 1'b0; end
            if (bus.r1_ack) begin done1 = 1'b1; bus.r1_req = 1'b0; end
        end
        if (!(done0 && done1)) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack timeout: r0 done %0d r1 done %0d, required both", done0, done1);
            bus.r0_req = 1'b0;
            bus.r1_req = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- monitor ----------------
    logic [64:0] e0;
    logic [67:0] ew;
    logic [31:0] m;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.r0_ack) begin
                if (exp_q0.size() == 0) check("r0 unexpected ack", 68'd1, 68'd0);
                else begin
                    e0 = exp_q0.pop_front();
                    check("r0 ack cycle", 68'(cyc), 68'(e0[64:33]));
                    check("r0 err", 68'(bus.r0_err), 68'(e0[32]));
                    check("r0 rdata", 68'(bus.r0_rdata), 68'(e0[31:0]));
                end
            end
            if (bus.r1_ack) begin
                if (exp_q1.size() == 0) check("r1 unexpected ack", 68'd1, 68'd0);
                else begin
                    e0 = exp_q1.pop_front();
                    check("r1 ack cycle", 68'(cyc), 68'(e0[64:33]));
                    check("r1 err", 68'(bus.r1_err), 68'(e0[32]));
                    check("r1 rdata", 68'(bus.r1_rdata), 68'(e0[31:0]));
                end
            end
            if (bus.mem_wren != 4'h0) begin
                if (exp_wr_q.size() == 0) check("unexpected write", 68'(bus.mem_wren), 68'd0);
                else begin
                    ew = exp_wr_q.pop_front();
                    m  = {{8{ew[35]}}, {8{ew[34]}}, {8{ew[33]}}, {8{ew[32]}}};
                    check("write addr", 68'(bus.mem_addr), 68'(ew[67:36]));
                    check("write lanes", 68'(bus.mem_wren), 68'(ew[35:32]));
                    check("write data", 68'(bus.mem_wdata & m), 68'(ew[31:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    txn_t idle_t, a, b;
    int   sel, mask, gap;

    initial begin
        idle_t = '0;
        bus.r0_req = 1'b0; bus.r0_addr = '0; bus.r0_we = 1'b0;
        bus.r0_size = '0; bus.r0_signed = 1'b0; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_addr = '0; bus.r1_we = 1'b0;
        bus.r1_size = '0; bus.r1_signed = 1'b0; bus.r1_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", 68'(dbg_state), 68'd0);
        check("reset ack/err", 68'({bus.r0_ack, bus.r1_ack, bus.r0_err, bus.r1_err}), 68'd0);
        check("reset rdata", 68'({bus.r0_rdata, bus.r1_rdata}), 68'd0);
        check("reset mem_addr", 68'(bus.mem_addr), 68'd0);
        check("reset mem_wdata", 68'(bus.mem_wdata), 68'd0);
        check("reset mem_wren", 68'(bus.mem_wren), 68'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store/load, then signed byte store/load.
        issue_round(1'b1, mk(32'h100, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF), 1'b0, idle_t);
        issue_round(1'b1, mk(32'h100, 1'b0, 2'd2, 1'b0, 32'h0), 1'b0, idle_t);
        issue_round(1'b1, mk(32'h101, 1'b1, 2'd0, 1'b0, 32'h0000_0080), 1'b0, idle_t);
        issue_round(1'b1, mk(32'h101, 1'b0, 2'd0, 1'b1, 32'h0), 1'b0, idle_t);

        // Simultaneous requests, repeated.
        for (int i = 0; i < 4; i++) begin
            issue_round(1'b1, mk(32'h100, 1'b0, 2'd2, 1'b0, 32'h0),
                        1'b1, mk(32'h100 + 32'(4*i), 1'b0, 2'd1, 1'b1, 32'h0));
        end

        // Misaligned word store/load; reserved size.
        issue_round(1'b1, mk(32'h203, 1'b1, 2'd2, 1'b0, 32'h1122_3344), 1'b0, idle_t);
        issue_round(1'b1, mk(32'h203, 1'b0, 2'd2, 1'b0, 32'h0), 1'b0, idle_t);
        issue_round(1'b0, idle_t, 1'b1, mk(32'h204, 1'b1, 2'd3, 1'b0, 32'hFFFF_FFFF));
        issue_round(1'b0, idle_t, 1'b1, mk(32'h205, 1'b0, 2'd1, 1'b0, 32'h0));

        // Reset during the memory cycle of an aligned store.
        bus.r0_req = 1'b1; bus.r0_addr = 32'h300; bus.r0_we = 1'b1;
        bus.r0_size = 2'd2; bus.r0_signed = 1'b0; bus.r0_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("store cycle lanes", 68'(bus.mem_wren), 68'hF);
        check("store cycle addr", 68'(bus.mem_addr), 68'h300);
        rst_n = 1'b0;
        #1;
        check("reset clears lanes", 68'(bus.mem_wren), 68'd0);
        check("reset clears ack", 68'({bus.r0_ack, bus.r1_ack}), 68'd0);
        bus.r0_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_grant = 1;
        @(posedge clk); #1;
        check("idle after reset", 68'(dbg_state), 68'd0);
        check("aborted store absent", 68'(tb_mem[8'hC0]),
              68'({ref_mem[10'h303], ref_mem[10'h302], ref_mem[10'h301], ref_mem[10'h300]}));

        // First tie after reset goes to r0 under round-robin.
        issue_round(1'b1, mk(32'h300, 1'b0, 2'd2, 1'b0, 32'h0),
                    1'b1, mk(32'h100, 1'b0, 2'd2, 1'b0, 32'h0));

        // Random traffic.
        for (int r = 0; r < 250; r++) begin
            mask = $urandom_range(1, 3);
            sel  = $urandom_range(0, 9);
            a = mk(32'($urandom_range(0, 32'h3F0)), 1'($urandom_range(0, 1)),
                   (sel == 9) ? 2'd3 : 2'(sel / 3), 1'($urandom_range(0, 1)), $urandom);
            sel  = $urandom_range(0, 9);
            b = mk(32'($urandom_range(0, 32'h3F0)), 1'($urandom_range(0, 1)),
                   (sel == 9) ? 2'd3 : 2'(sel / 3), 1'($urandom_range(0, 1)), $urandom);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            issue_round(mask[0], a, mask[1], b);
        end

        repeat (5) @(posedge clk);
        #1;
        check("expectations drained", 68'(exp_q0.size() + exp_q1.size() + exp_wr_q.size()), 68'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
